// File: rtl/qed_pair_scanner.sv
// qed_pair_scanner: after a QED sequence is armed, snapshots the register
// file on each check trigger and compares original/duplicate register pairs
// LANES at a time, reporting pass/fail, the lowest failing pair and
// saturating check/fail counts.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | not armed, triggers ignored
// ARMED   | waiting for a trigger (qed_check_valid && sif_commit)
// SCAN    | comparing one chunk of LANES pairs per cycle from the snapshot
// REPORT  | publishing the result, then back to ARMED
module qed_pair_scanner #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int LANES      = 4,
  parameter int CHECK_ZERO = 1,
  parameter int CNT_W      = 8,
  localparam int H         = NUM_REGS / 2,
  localparam int IDX_W     = (H > 1) ? $clog2(H) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sif_commit_pulsed,
  input  logic                           sif_commit,
  input  logic                           qed_check_valid,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [IDX_W-1:0]               first_mismatch_idx,
  output logic                           mismatch_sticky,
  output logic                           overrun_sticky,
  output logic [CNT_W-1:0]               check_count,
  output logic [CNT_W-1:0]               fail_count
);

  // Pointer is wide enough to hold the first index past the last chunk.
  localparam int PTR_W = $clog2(H + LANES) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_SCAN   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] snap_q;
  logic [PTR_W-1:0]               ptr_q;
  logic                           fail_any_q;
  logic [IDX_W-1:0]               first_q;
  logic                           trigger;
  logic                           last_chunk;
  logic                           chunk_fail;
  logic [IDX_W-1:0]               chunk_idx;

  assign trigger    = qed_check_valid & sif_commit;
  assign last_chunk = (int'(ptr_q) + LANES) >= H;
  assign busy       = (state_q == S_SCAN) || (state_q == S_REPORT);

  // Pair 0 is the zero-register check when CHECK_ZERO is set, otherwise
  // exempt; every other pair must match its duplicate exactly.
  function automatic logic pair_fail(input logic [NUM_REGS*DATA_WIDTH-1:0] s,
                                     input int j);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    a = s[j*DATA_WIDTH +: DATA_WIDTH];
    b = s[(j+H)*DATA_WIDTH +: DATA_WIDTH];
    if (j == 0) begin
      return (CHECK_ZERO != 0) ? ((a != '0) || (b != '0)) : 1'b0;
    end
    return a != b;
  endfunction

  // Compare the current chunk; walk lanes high to low so the lowest
  // failing pair of the chunk is the one left in chunk_idx.
  always_comb begin
    chunk_fail = 1'b0;
    chunk_idx  = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if ((int'(ptr_q) + l) < H) begin
        if (pair_fail(snap_q, int'(ptr_q) + l)) begin
          chunk_fail = 1'b1;
          chunk_idx  = IDX_W'(int'(ptr_q) + l);
        end
      end
    end
  end

  // Next-state logic; arming during SCAN/REPORT aborts the check.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sif_commit_pulsed) state_d = S_ARMED;
      S_ARMED:  if (trigger) state_d = S_SCAN;
      S_SCAN: begin
        if (sif_commit_pulsed)  state_d = S_ARMED;
        else if (last_chunk)    state_d = S_REPORT;
      end
      S_REPORT: state_d = S_ARMED;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Snapshot, chunk pointer, per-check fail tracking and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q              <= '0;
      fail_any_q         <= 1'b0;
      first_q            <= '0;
      done               <= 1'b0;
      pass               <= 1'b0;
      first_mismatch_idx <= '0;
      mismatch_sticky    <= 1'b0;
      overrun_sticky     <= 1'b0;
      check_count        <= '0;
      fail_count         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_ARMED: begin
          if (trigger) begin
            snap_q     <= regs_flat;
            ptr_q      <= '0;
            fail_any_q <= 1'b0;
            first_q    <= '0;
          end
        end
        S_SCAN: begin
          if (trigger) overrun_sticky <= 1'b1;
          if (!sif_commit_pulsed) begin
            ptr_q <= ptr_q + PTR_W'(LANES);
            if (chunk_fail) begin
              fail_any_q <= 1'b1;
              if (!fail_any_q) first_q <= chunk_idx;
            end
          end
        end
        S_REPORT: begin
          if (trigger) overrun_sticky <= 1'b1;
          if (!sif_commit_pulsed) begin
            done               <= 1'b1;
            pass               <= ~fail_any_q;
            first_mismatch_idx <= fail_any_q ? first_q : '0;
            if (fail_any_q) mismatch_sticky <= 1'b1;
            if (check_count != '1) check_count <= check_count + 1'b1;
            if (fail_any_q && (fail_count != '1)) fail_count <= fail_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qed_pair_scanner.sv
// Bench for qed_pair_scanner: three instances (defaults; CHECK_ZERO=0 with
// 2-bit counters; 8 regs x 8 bits with 3 lanes) share the control inputs.
// Expected results are queued when a trigger is driven and compared when
// each instance pulses done.
module tb_qed_pair_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, arm, commit, qcv;
  logic [31:0]   r  [32];
  logic [7:0]    rc [8];
  logic [1023:0] flat;
  logic [63:0]   flat_c;

  always_comb begin
    flat = '0;
    for (int i = 0; i < 32; i++) flat[i*32 +: 32] = r[i];
  end
  always_comb begin
    flat_c = '0;
    for (int i = 0; i < 8; i++) flat_c[i*8 +: 8] = rc[i];
  end

  logic       busy_a, done_a, pass_a, ms_a, os_a;
  logic [3:0] idx_a;
  logic [7:0] cc_a, fc_a;
  logic       busy_b, done_b, pass_b, ms_b, os_b;
  logic [3:0] idx_b;
  logic [1:0] cc_b, fc_b;
  logic       busy_c, done_c, pass_c, ms_c, os_c;
  logic [1:0] idx_c;
  logic [7:0] cc_c, fc_c;

  qed_pair_scanner u_dut_a (
    .clk(clk), .rst(rst), .sif_commit_pulsed(arm), .sif_commit(commit),
    .qed_check_valid(qcv), .regs_flat(flat), .busy(busy_a), .done(done_a),
    .pass(pass_a), .first_mismatch_idx(idx_a), .mismatch_sticky(ms_a),
    .overrun_sticky(os_a), .check_count(cc_a), .fail_count(fc_a));

  qed_pair_scanner #(.CHECK_ZERO(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .sif_commit_pulsed(arm), .sif_commit(commit),
    .qed_check_valid(qcv), .regs_flat(flat), .busy(busy_b), .done(done_b),
    .pass(pass_b), .first_mismatch_idx(idx_b), .mismatch_sticky(ms_b),
    .overrun_sticky(os_b), .check_count(cc_b), .fail_count(fc_b));

  qed_pair_scanner #(.DATA_WIDTH(8), .NUM_REGS(8), .LANES(3)) u_dut_c (
    .clk(clk), .rst(rst), .sif_commit_pulsed(arm), .sif_commit(commit),
    .qed_check_valid(qcv), .regs_flat(flat_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .first_mismatch_idx(idx_c), .mismatch_sticky(ms_c),
    .overrun_sticky(os_c), .check_count(cc_c), .fail_count(fc_c));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic       p;
    logic [7:0] idx;
    logic [7:0] cc;
    logic [7:0] fc;
    logic       ms;
    int         due;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   m_cc[3], m_fc[3];
  bit   m_ms[3];

  // Reference evaluation of one check for instance sel (0=a, 1=b, 2=c).
  function automatic void eval(input int sel, output logic p, output logic [7:0] idx);
    int   h;
    bit   cz;
    logic f;
    h   = (sel == 2) ? 4 : 16;
    cz  = (sel != 1);
    p   = 1'b1;
    idx = 8'd0;
    for (int j = h - 1; j >= 0; j--) begin
      if (sel == 2) f = (j == 0) ? (cz && (rc[0] != 0 || rc[4] != 0)) : (rc[j] != rc[j+4]);
      else          f = (j == 0) ? (cz && (r[0] != 0 || r[16] != 0)) : (r[j] != r[j+16]);
      if (f) begin
        p   = 1'b0;
        idx = 8'(j);
      end
    end
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v < max) ? v + 1 : max;
  endfunction

  // Called one half-cycle before the trigger edge T.
  task automatic sb_push();
    exp_t e;
    int   lat[3];
    int   mx[3];
    lat = '{5, 5, 3};
    mx  = '{255, 3, 255};
    for (int s = 0; s < 3; s++) begin
      eval(s, e.p, e.idx);
      m_cc[s] = sat_inc(m_cc[s], mx[s]);
      if (!e.p) begin
        m_fc[s] = sat_inc(m_fc[s], mx[s]);
        m_ms[s] = 1'b1;
      end
      e.cc  = 8'(m_cc[s]);
      e.fc  = 8'(m_fc[s]);
      e.ms  = m_ms[s];
      e.due = cyc + 1 + lat[s];
      if (s == 0) qa.push_back(e);
      else if (s == 1) qb.push_back(e);
      else qc.push_back(e);
    end
  endtask

  // Scoreboard: each done pulse is matched with the oldest expected result.
  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) check("a_spurious_done", 1, 0);
      else begin
        ea = qa.pop_front();
        check("a_done_cycle", cyc, ea.due);
        check("a_pass", pass_a, ea.p);
        check("a_idx", idx_a, ea.idx);
        check("a_check_count", cc_a, ea.cc);
        check("a_fail_count", fc_a, ea.fc);
        check("a_mismatch_sticky", ms_a, ea.ms);
      end
    end
    if (done_b) begin
      if (qb.size() == 0) check("b_spurious_done", 1, 0);
      else begin
        eb = qb.pop_front();
        check("b_done_cycle", cyc, eb.due);
        check("b_pass", pass_b, eb.p);
        check("b_idx", idx_b, eb.idx);
        check("b_check_count", cc_b, eb.cc);
        check("b_fail_count", fc_b, eb.fc);
      end
    end
    if (done_c) begin
      if (qc.size() == 0) check("c_spurious_done", 1, 0);
      else begin
        ec = qc.pop_front();
        check("c_done_cycle", cyc, ec.due);
        check("c_pass", pass_c, ec.p);
        check("c_idx", idx_c, ec.idx);
        check("c_check_count", cc_c, ec.cc);
        check("c_fail_count", fc_c, ec.fc);
      end
    end
  end

  task automatic set_consistent();
    logic [31:0] v;
    logic [7:0]  w;
    for (int j = 0; j < 16; j++) begin
      v = (j == 0) ? 32'd0 : $urandom;
      r[j]    = v;
      r[j+16] = v;
    end
    for (int j = 0; j < 4; j++) begin
      w = (j == 0) ? 8'd0 : 8'($urandom);
      rc[j]   = w;
      rc[j+4] = w;
    end
  endtask

  task automatic trig(input bit push);
    @(negedge clk);
    commit = 1'b1;
    qcv    = 1'b1;
    if (push) sb_push();
    @(posedge clk);
    #1;
    commit = 1'b0;
    qcv    = 1'b0;
  endtask

  task automatic do_arm();
    @(negedge clk);
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout", qa.size() + qb.size() + qc.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_mismatch_sticky", ms_a, 0);
    check("rst_overrun_sticky", os_a, 0);
    check("rst_check_count", cc_a, 0);
    check("rst_fail_count", fc_a, 0);
    check("rst_c_busy", busy_c, 0);
    check("rst_c_count", cc_c, 0);
    for (int s = 0; s < 3; s++) begin
      m_cc[s] = 0;
      m_fc[s] = 0;
      m_ms[s] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; commit = 1'b0; qcv = 1'b0;
    for (int s = 0; s < 3; s++) begin
      m_cc[s] = 0; m_fc[s] = 0; m_ms[s] = 1'b0;
    end
    set_consistent();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;

    // Trigger in IDLE is ignored.
    trig(0);
    @(negedge clk);
    check("idle_trigger_busy", busy_a, 0);

    // Arm and trigger together in IDLE: arm only.
    @(negedge clk);
    arm = 1'b1; commit = 1'b1; qcv = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0; commit = 1'b0; qcv = 1'b0;
    @(negedge clk);
    check("arm_and_trigger_busy", busy_a, 0);
    repeat (6) @(negedge clk);
    check("arm_and_trigger_count", cc_a, 0);

    // Consistent registers: busy for cycles T..T+4, pass.
    trig(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("busy_during_scan", busy_a, 1);
    end
    @(negedge clk);
    check("busy_after_report", busy_a, 0);
    wait_idle();

    // Mismatches at pairs 3 and 5; c fails at pair 3 in its second chunk.
    r[5] = 32'hA; r[21] = 32'hB; r[19] = ~r[3];
    rc[3] = 8'd5; rc[7] = 8'd6;
    trig(1);
    wait_idle();
    check("fail_idx_is_3", idx_a, 3);
    check("fail_mismatch_sticky", ms_a, 1);

    // Nonzero reg[H]: fails pair 0 only when CHECK_ZERO is set.
    set_consistent();
    r[16] = 32'd1;
    trig(1);
    wait_idle();
    check("zero_check_b_pass", pass_b, 1);

    // Second trigger at T+2 while busy, with registers changed after snapshot.
    set_consistent();
    trig(1);
    @(negedge clk);
    @(negedge clk);
    r[7] = ~r[23];
    commit = 1'b1; qcv = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0; qcv = 1'b0;
    wait_idle();
    check("overrun_sticky", os_a, 1);
    check("overrun_pass_first_snapshot", pass_a, 1);
    set_consistent();

    // Re-arm at T+3 aborts the scan (c is in REPORT then) and stays armed.
    trig(0);
    repeat (3) @(negedge clk);
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_check_count", cc_a, 8'(m_cc[0]));
    check("abort_c_check_count", cc_c, 8'(m_cc[2]));
    check("abort_busy", busy_a, 0);
    check("abort_keeps_overrun", os_a, 1);
    trig(1);
    wait_idle();

    // Reset at T+3 mid-scan: no done, everything back to reset values.
    r[9] = ~r[25];
    trig(0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_count", cc_a, 0);

    // Five failing checks: the 2-bit counters saturate at 3.
    do_arm();
    for (int n = 0; n < 5; n++) begin
      trig(1);
      wait_idle();
    end
    check("sat_b_fail_count", fc_b, 3);
    check("sat_b_check_count", cc_b, 3);
    check("sat_a_fail_count", fc_a, 5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
